// File: rtl/bram_copy_engine.sv
// Block-copy initiator for a dual-port BRAM.
// Reads a run of words through port A and writes them through port B at one word per clock.
module bram_copy_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  I_CLK,
    input  logic                  I_RESET,
    input  logic                  I_START,
    input  logic [ADDR_WIDTH-1:0] I_SRC_ADDR,
    input  logic [ADDR_WIDTH-1:0] I_DST_ADDR,
    input  logic [ADDR_WIDTH:0]   I_LENGTH,
    output logic                  O_BUSY,
    output logic                  O_DONE,
    output logic [ADDR_WIDTH:0]   O_COUNT,
    output logic [ADDR_WIDTH-1:0] O_ADDRESS_A,
    input  logic [DATA_WIDTH-1:0] I_DATA_A,
    output logic [ADDR_WIDTH-1:0] O_ADDRESS_B,
    output logic [DATA_WIDTH-1:0] O_DATA_B,
    output logic                  O_WRITE_ENABLE_B
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH + 1)'(1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] src;
    logic [ADDR_WIDTH-1:0] dst;
    logic [ADDR_WIDTH:0]   len;
    logic [ADDR_WIDTH:0]   rd_cnt;
    logic [ADDR_WIDTH:0]   wr_cnt;
    logic                  rd_valid;
    logic [ADDR_WIDTH:0]   len_clamped;
    logic [ADDR_WIDTH:0]   rd_next;
    logic [ADDR_WIDTH:0]   wr_next;

    assign len_clamped = (I_LENGTH > MAX_LEN) ? MAX_LEN : I_LENGTH;
    assign rd_next     = rd_cnt + ONE;
    assign wr_next     = wr_cnt + ONE;

    // rd_valid marks that port A captured an address on the previous edge,
    // so I_DATA_A holds a word that must be forwarded to port B on this edge.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state            <= IDLE;
            src              <= '0;
            dst              <= '0;
            len              <= '0;
            rd_cnt           <= '0;
            wr_cnt           <= '0;
            rd_valid         <= 1'b0;
            O_BUSY           <= 1'b0;
            O_DONE           <= 1'b0;
            O_COUNT          <= '0;
            O_ADDRESS_A      <= '0;
            O_ADDRESS_B      <= '0;
            O_DATA_B         <= '0;
            O_WRITE_ENABLE_B <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            O_DONE   <= 1'b0;

            if (rd_valid) begin
                O_DATA_B         <= I_DATA_A;
                O_ADDRESS_B      <= dst + wr_cnt[ADDR_WIDTH-1:0];
                O_WRITE_ENABLE_B <= 1'b1;
                wr_cnt           <= wr_next;
            end else begin
                O_WRITE_ENABLE_B <= 1'b0;
            end

            if (O_WRITE_ENABLE_B) begin
                O_COUNT <= O_COUNT + ONE;
            end

            case (state)
                IDLE: begin
                    if (I_START) begin
                        src         <= I_SRC_ADDR;
                        dst         <= I_DST_ADDR;
                        len         <= len_clamped;
                        rd_cnt      <= '0;
                        wr_cnt      <= '0;
                        O_COUNT     <= '0;
                        O_BUSY      <= 1'b1;
                        O_ADDRESS_A <= I_SRC_ADDR;
                        state       <= (len_clamped == '0) ? FINISH : RUN;
                    end
                end
                RUN: begin
                    rd_valid <= 1'b1;
                    rd_cnt   <= rd_next;
                    // The read address holds on the last word rather than running ahead.
                    if (rd_next == len) begin
                        state <= DRAIN;
                    end else begin
                        O_ADDRESS_A <= src + rd_next[ADDR_WIDTH-1:0];
                    end
                end
                DRAIN: begin
                    if (rd_valid && wr_next == len) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    O_DONE <= 1'b1;
                    O_BUSY <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_copy_engine.sv
// Self-checking bench for bram_copy_engine: a BRAM model, a snapshot-copy
// reference memory, a vector table, hand-written corner sequences and random copies.
module tb_bram_copy_engine;

    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
    logic [AW-1:0] address_a;
    logic [DW-1:0] data_a;
    logic [AW-1:0] address_b;
    logic [DW-1:0] data_b;
    logic          write_enable_b;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] exp_mem [DEPTH];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    int cyc      = 0;
    int we_cnt   = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_edge = 0;
    int checks   = 0;
    int errors   = 0;

    typedef struct {
        int src;
        int dst;
        int len;
        int exp_writes;
        int exp_count;
        int exp_lat;
    } vec_t;

    vec_t vecs [7];

    bram_copy_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .I_CLK            (clk),
        .I_RESET          (rst),
        .I_START          (start),
        .I_SRC_ADDR       (src_addr),
        .I_DST_ADDR       (dst_addr),
        .I_LENGTH         (length),
        .O_BUSY           (busy),
        .O_DONE           (done),
        .O_COUNT          (count),
        .O_ADDRESS_A      (address_a),
        .I_DATA_A         (data_a),
        .O_ADDRESS_B      (address_b),
        .O_DATA_B         (data_b),
        .O_WRITE_ENABLE_B (write_enable_b)
    );

    always #5 clk = ~clk;

    // Read-first BRAM: a same-edge read and write to one address returns the old word.
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (write_enable_b) begin
            mem[address_b] <= data_b;
        end
        data_a <= mem[address_a];
        cyc++;
    end

    always @(negedge clk) begin
        if (write_enable_b) we_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic preload(input int addr, input logic [DW-1:0] val);
        pre_addr = addr[AW-1:0];
        pre_data = val;
        pre_we   = 1'b1;
        @(posedge clk);
        #1;
        pre_we   = 1'b0;
        exp_mem[addr] = val;
    endtask

    // Reference: every destination word takes the source word as it stood before the copy.
    task automatic model_copy(input int s, input int d, input int n);
        logic [DW-1:0] snap [DEPTH];
        snap = exp_mem;
        for (int i = 0; i < n; i++) begin
            exp_mem[(d + i) % DEPTH] = snap[(s + i) % DEPTH];
        end
    endtask

    task automatic check_mem(input string name);
        int diffs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i] !== exp_mem[i]) diffs++;
        end
        checkOutput($sformatf("%s_mem_diffs", name), diffs, 0);
    endtask

    task automatic check_idle_outputs(input string name);
        checkOutput($sformatf("%s_busy", name), busy, 0);
        checkOutput($sformatf("%s_done", name), done, 0);
        checkOutput($sformatf("%s_count", name), count, 0);
        checkOutput($sformatf("%s_addr_a", name), address_a, 0);
        checkOutput($sformatf("%s_addr_b", name), address_b, 0);
        checkOutput($sformatf("%s_data_b", name), data_b, 0);
        checkOutput($sformatf("%s_we_b", name), write_enable_b, 0);
    endtask

    task automatic applyStimulus(input int s, input int d, input int l);
        src_addr = s[AW-1:0];
        dst_addr = d[AW-1:0];
        length   = l[AW:0];
        start    = 1'b1;
        @(posedge clk);
        #1;
        start_edge = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int glitch, input int done_base,
                             input string name, output bit ok);
        int n = 0;
        while (done_cnt == done_base && n < budget) begin
            @(negedge clk);
            #1;
            n++;
            if (glitch != 0 && n == glitch) begin
                start    = 1'b1;
                src_addr = AW'($urandom);
                dst_addr = AW'($urandom);
                length   = (AW + 1)'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        ok = (done_cnt != done_base);
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
    endtask

    task automatic run_copy(input int s, input int d, input int l, input int exp_writes,
                            input int exp_count, input int exp_lat, input int glitch,
                            input string name);
        int  n;
        int  wb;
        int  db;
        bit  ok;
        n  = (l > DEPTH) ? DEPTH : l;
        model_copy(s, d, n);
        wb = we_cnt;
        db = done_cnt;
        applyStimulus(s, d, l);
        checkOutput($sformatf("%s_busy_after_start", name), busy, 1);
        checkOutput($sformatf("%s_addr_a_after_start", name), address_a, s);
        wait_done(exp_lat + 20, glitch, db, name, ok);
        if (ok) begin
            checkOutput($sformatf("%s_done_latency", name), done_cyc - start_edge, exp_lat);
            checkOutput($sformatf("%s_busy_in_done", name), busy, 0);
            checkOutput($sformatf("%s_count", name), count, exp_count);
            checkOutput($sformatf("%s_we_cycles", name), we_cnt - wb, exp_writes);
            @(negedge clk);
            #1;
            checkOutput($sformatf("%s_done_pulses", name), done_cnt - db, 1);
            checkOutput($sformatf("%s_count_hold", name), count, exp_count);
        end
        check_mem(name);
    endtask

    initial begin
        bit ok;
        int wb;
        int db;
        int exp_ov [5];

        rst      = 1'b1;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            preload(i, DW'($urandom));
        end
        for (int i = 0; i < 8; i++) begin
            preload(i, DW'(i + 1));
        end

        vecs[0] = '{src: 0,    dst: 16,   len: 8,    exp_writes: 8,    exp_count: 8,    exp_lat: 10};
        vecs[1] = '{src: 5,    dst: 200,  len: 0,    exp_writes: 0,    exp_count: 0,    exp_lat: 1};
        vecs[2] = '{src: 1020, dst: 100,  len: 8,    exp_writes: 8,    exp_count: 8,    exp_lat: 10};
        vecs[3] = '{src: 500,  dst: 1022, len: 8,    exp_writes: 8,    exp_count: 8,    exp_lat: 10};
        vecs[4] = '{src: 300,  dst: 400,  len: 1,    exp_writes: 1,    exp_count: 1,    exp_lat: 3};
        vecs[5] = '{src: 600,  dst: 598,  len: 10,   exp_writes: 10,   exp_count: 10,   exp_lat: 12};
        vecs[6] = '{src: 0,    dst: 0,    len: 2000, exp_writes: 1024, exp_count: 1024, exp_lat: 1026};

        for (int v = 0; v < 7; v++) begin
            run_copy(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].exp_writes,
                     vecs[v].exp_count, vecs[v].exp_lat, 0, $sformatf("vec%0d", v));
        end

        // Basic copy lands the preloaded 1..8 at 16..23.
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("basic_word%0d", i), mem[16 + i], i + 1);
        end

        // dst = src + 1 shifts the run up by one word.
        for (int i = 0; i < 5; i++) begin
            preload(50 + i, DW'(i + 1));
        end
        run_copy(50, 51, 4, 4, 4, 6, 0, "overlap");
        exp_ov = '{1, 1, 2, 3, 4};
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("overlap_word%0d", i), mem[50 + i], exp_ov[i]);
        end

        // A start pulse in the middle of a copy is ignored.
        run_copy(10, 600, 12, 12, 12, 14, 3, "ignore_start");

        // Back-to-back: second start issued during the done cycle of the first.
        model_copy(100, 700, 5);
        db = done_cnt;
        applyStimulus(100, 700, 5);
        wait_done(30, 0, db, "b2b_a", ok);
        if (ok) begin
            checkOutput("b2b_a_count", count, 5);
            model_copy(110, 720, 6);
            db = done_cnt;
            wb = we_cnt;
            applyStimulus(110, 720, 6);
            checkOutput("b2b_busy", busy, 1);
            checkOutput("b2b_done_low", done, 0);
            wait_done(30, 0, db, "b2b_b", ok);
            if (ok) begin
                checkOutput("b2b_b_latency", done_cyc - start_edge, 8);
                checkOutput("b2b_b_count", count, 6);
                checkOutput("b2b_b_we_cycles", we_cnt - wb, 6);
            end
        end
        @(negedge clk);
        #1;
        check_mem("b2b");

        // Reset after three committed writes stops the copy at once.
        applyStimulus(200, 800, 10);
        begin
            int n = 0;
            while (count != 3 && n < 30) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        checkOutput("rst_mid_reached_three", count, 3);
        rst = 1'b1;
        #1;
        check_idle_outputs("rst_mid");
        model_copy(200, 800, 3);
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("rst_hold");
        check_mem("rst_mid");
        rst = 1'b0;
        @(negedge clk);
        #1;
        run_copy(200, 800, 10, 10, 10, 12, 0, "after_rst");

        // Random copies: disjoint destinations or destinations at or below the source.
        for (int t = 0; t < 12; t++) begin
            int l;
            int s;
            int d;
            l = int'($urandom_range(0, 40));
            s = int'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 1) == 1) begin
                d = (s + l + int'($urandom_range(0, DEPTH - 2 * l))) % DEPTH;
            end else begin
                d = (s + DEPTH - int'($urandom_range(0, l))) % DEPTH;
            end
            run_copy(s, d, l, l, l, (l == 0) ? 1 : l + 2, 0, $sformatf("rand%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
